// File: rtl/sram_cmp_scan.sv
// Masked burst comparator: checks LEN readback/expected word pairs and reports a
// per-beat mismatch, a sticky fail flag, a saturating error count and the first failing index.
module sram_cmp_scan #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [IDX_W-1:0]  len_i,
    input  logic [DATA_W-1:0] mask_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] d1_i,
    input  logic [DATA_W-1:0] d2_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              mis_o,
    output logic              result_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [IDX_W-1:0]  first_idx_o,
    output logic              first_vld_o,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a beat transfers on a rising edge where valid_i && ready_o;
    // ready_o is high only in RUN and does not depend on valid_i.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             r_state;
    logic [IDX_W-1:0]   r_len;
    logic [DATA_W-1:0]  r_mask;
    logic [IDX_W-1:0]   r_idx;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_mis;
    logic               r_result;
    logic [CNT_W-1:0]   r_err;
    logic [IDX_W-1:0]   r_first_idx;
    logic               r_first_vld;

    logic               w_accept;
    logic               w_mismatch;
    logic               w_last;

    assign w_accept   = valid_i && r_ready;
    assign w_mismatch = |((d1_i ^ d2_i) & r_mask);
    assign w_last     = (r_idx == (r_len - IDX_ONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_mask      <= '0;
            r_idx       <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mis       <= 1'b0;
            r_result    <= 1'b0;
            r_err       <= '0;
            r_first_idx <= '0;
            r_first_vld <= 1'b0;
        end else begin
            r_mis <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_len       <= len_i;
                        r_mask      <= mask_i;
                        r_idx       <= '0;
                        r_result    <= 1'b0;
                        r_err       <= '0;
                        r_first_idx <= '0;
                        r_first_vld <= 1'b0;
                        r_busy      <= 1'b1;
                        // An empty scan goes straight to DONE without compares
                        if (len_i == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_mis <= w_mismatch;
                        r_idx <= r_idx + IDX_ONE;
                        if (w_mismatch) begin
                            r_result <= 1'b1;
                            if (r_err != CNT_MAX) begin
                                r_err <= r_err + CNT_ONE;
                            end
                            if (!r_first_vld) begin
                                r_first_idx <= r_idx;
                                r_first_vld <= 1'b1;
                            end
                        end
                        if (w_last) begin
                            r_state <= DONE;
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o     = r_ready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign mis_o       = r_mis;
    assign result_o    = r_result;
    assign err_cnt_o   = r_err;
    assign first_idx_o = r_first_idx;
    assign first_vld_o = r_first_vld;
    assign dbg_state_o = r_state;

endmodule
